// File: rtl/tank_sprite_gen2.sv
// Tank sprite generator: maps a 128x128 world position to display coordinates,
// renders a 2^SPR_LOG2 square sprite in one of four orientations, and runs the
// explosion -> respawn pulse -> blinking invulnerability sequence after a hit.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   pixel_column, pixel_row    current display pixel
//   loc_x, loc_y               world position of the tank
//   bot_info                   [2:0] orientation code (odd = diagonal, keep last)
//   hit                        hit strobe (level or pulse)
//   tank_addr / tank_data      tank ROM address (registered) and palette index
//   boom_addr / boom_data      explosion ROM address {frame, addr} and RGB
//   icon, icon_c               sprite opaque flag and RGB, 2 clocks after the pixel
//   burst, tank_reset, guard   explosion active, respawn pulse, invulnerable window
//
// tank_addr/boom_addr are the ROM address registers; ROM data is consumed in the
// following cycle, so icon/icon_c land exactly 2 clocks after the pixel input.
module tank_sprite_gen2 #(
  parameter int unsigned SPR_LOG2         = 5,
  parameter int unsigned SCALE_X          = 8,
  parameter int unsigned SCALE_Y          = 6,
  parameter int unsigned BOOM_FRAMES_LOG2 = 2,
  parameter int unsigned FRAME_CYCLES     = 12500000,
  parameter int unsigned RESET_PULSE      = 16,
  parameter int unsigned GUARD_CYCLES     = 50000000,
  parameter int unsigned BLINK_LOG2       = 22,
  parameter logic [11:0] TANK_COLOR       = 12'h00F
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [11:0]                            pixel_column,
  input  logic [11:0]                            pixel_row,
  input  logic [7:0]                             loc_x,
  input  logic [7:0]                             loc_y,
  input  logic [7:0]                             bot_info,
  input  logic                                   hit,
  output logic [2*SPR_LOG2-1:0]                  tank_addr,
  input  logic [1:0]                             tank_data,
  output logic [BOOM_FRAMES_LOG2+2*SPR_LOG2-1:0] boom_addr,
  input  logic [11:0]                            boom_data,
  output logic                                   icon,
  output logic [11:0]                            icon_c,
  output logic                                   burst,
  output logic                                   tank_reset,
  output logic                                   guard
);

  localparam int unsigned SprW   = 1 << SPR_LOG2;
  localparam int unsigned CntMax01 = (FRAME_CYCLES > RESET_PULSE) ? FRAME_CYCLES : RESET_PULSE;
  localparam int unsigned CntMax = (CntMax01 > GUARD_CYCLES) ? CntMax01 : GUARD_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StAlive, StBurst, StRespawn, StGuard} state_e;
  typedef enum logic [1:0] {OriN, OriE, OriS, OriW} orient_e;

  state_e                      state_q;
  orient_e                     orient_q, orient_eff;
  logic [CntW-1:0]             cnt_q;
  logic [BOOM_FRAMES_LOG2-1:0] frame_q;
  logic [BLINK_LOG2:0]         blink_q;

  logic [11:0]           col0, row0, dc, dr;
  logic [SPR_LOG2-1:0]   c_off, r_off;
  logic [2*SPR_LOG2-1:0] addr_d;
  logic                  win_d, gate_d;
  logic                  win_q, gate_q, boom_sel_q;
  logic                  icon_d;
  logic [11:0]           icon_c_d;

  logic unused_bot_info;
  assign unused_bot_info = ^bot_info[7:3];

  // Window test uses the difference only, so col0 + SprW is never formed.
  assign col0  = 12'(loc_x * SCALE_X);
  assign row0  = 12'(loc_y * SCALE_Y);
  assign dc    = pixel_column - col0;
  assign dr    = pixel_row - row0;
  assign c_off = dc[SPR_LOG2-1:0];
  assign r_off = dr[SPR_LOG2-1:0];
  assign win_d = (pixel_column >= col0) && (dc < 12'(SprW)) &&
                 (pixel_row >= row0) && (dr < 12'(SprW));

  // Diagonal (odd) codes fall back to the last cardinal orientation.
  assign orient_eff = bot_info[0] ? orient_q : orient_e'(bot_info[2:1]);

  always_comb begin
    addr_d = {r_off, c_off};
    unique case (orient_eff)
      OriN: addr_d = {r_off, c_off};
      OriE: addr_d = {~c_off, r_off};
      OriS: addr_d = {~r_off, ~c_off};
      OriW: addr_d = {c_off, ~r_off};
    endcase
  end

  assign gate_d = (state_q != StGuard) || blink_q[BLINK_LOG2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      orient_q <= OriN;
    end else if (!bot_info[0]) begin
      orient_q <= orient_e'(bot_info[2:1]);
    end
  end

  // Stage 1: ROM addresses plus the flags that must stay aligned with them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tank_addr  <= '0;
      boom_addr  <= '0;
      win_q      <= 1'b0;
      gate_q     <= 1'b0;
      boom_sel_q <= 1'b0;
    end else begin
      tank_addr  <= addr_d;
      boom_addr  <= {frame_q, addr_d};
      win_q      <= win_d;
      gate_q     <= gate_d;
      boom_sel_q <= (state_q == StBurst);
    end
  end

  // Stage 2: colour from ROM data; icon_c holds whenever nothing is drawn.
  always_comb begin
    icon_d   = 1'b0;
    icon_c_d = icon_c;
    if (win_q && gate_q) begin
      if (boom_sel_q) begin
        icon_d   = (boom_data != 12'hFFF);
        icon_c_d = boom_data;
      end else begin
        unique case (tank_data)
          2'd0: icon_d = 1'b0;
          2'd1: begin icon_d = 1'b1; icon_c_d = 12'h000;    end
          2'd2: begin icon_d = 1'b1; icon_c_d = TANK_COLOR; end
          2'd3: begin icon_d = 1'b1; icon_c_d = 12'h025;    end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icon   <= 1'b0;
      icon_c <= 12'h000;
    end else begin
      icon   <= icon_d;
      icon_c <= icon_c_d;
    end
  end

  // Hit sequence FSM; burst/tank_reset/guard are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StAlive;
      cnt_q      <= '0;
      frame_q    <= '0;
      blink_q    <= '0;
      burst      <= 1'b0;
      tank_reset <= 1'b0;
      guard      <= 1'b0;
    end else begin
      unique case (state_q)
        StAlive: begin
          if (hit) begin
            state_q <= StBurst;
            cnt_q   <= '0;
            frame_q <= '0;
            burst   <= 1'b1;
          end
        end
        StBurst: begin
          if (cnt_q == CntW'(FRAME_CYCLES - 1)) begin
            cnt_q <= '0;
            if (frame_q == '1) begin
              frame_q    <= '0;
              state_q    <= StRespawn;
              burst      <= 1'b0;
              tank_reset <= 1'b1;
            end else begin
              frame_q <= frame_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRespawn: begin
          if (cnt_q == CntW'(RESET_PULSE - 1)) begin
            cnt_q      <= '0;
            state_q    <= StGuard;
            tank_reset <= 1'b0;
            guard      <= 1'b1;
            blink_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGuard: begin
          blink_q <= blink_q + 1'b1;
          if (cnt_q == CntW'(GUARD_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= StAlive;
            guard   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StAlive;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_sprite_gen2.sv
module tb_tank_sprite_gen2;

  localparam int FC  = 4;
  localparam int RP  = 16;
  localparam int GC  = 64;
  localparam int BL  = 3;
  localparam int BLT = 4 * FC;      // explosion length (4 frames)
  localparam int TOT = BLT + RP + GC;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] pixel_column, pixel_row;
  logic [7:0]  loc_x, loc_y, bot_info;
  logic        hit;
  logic [9:0]  tank_addr;
  logic [1:0]  tank_data;
  logic [11:0] boom_addr;
  logic [11:0] boom_data;
  logic        icon;
  logic [11:0] icon_c;
  logic        burst, tank_reset, guard;

  int rom_mode;   // 0: every entry index 2, 1: index 1 at address 0 only
  int boom_mode;  // 0: 12'hFFF, 1: 12'hF80
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tank_sprite_gen2 #(
    .FRAME_CYCLES(FC),
    .RESET_PULSE (RP),
    .GUARD_CYCLES(GC),
    .BLINK_LOG2  (BL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_column(pixel_column),
    .pixel_row   (pixel_row),
    .loc_x       (loc_x),
    .loc_y       (loc_y),
    .bot_info    (bot_info),
    .hit         (hit),
    .tank_addr   (tank_addr),
    .tank_data   (tank_data),
    .boom_addr   (boom_addr),
    .boom_data   (boom_data),
    .icon        (icon),
    .icon_c      (icon_c),
    .burst       (burst),
    .tank_reset  (tank_reset),
    .guard       (guard)
  );

  function automatic int rom_idx(input int a);
    if (rom_mode == 0) return 2;
    return (a == 0) ? 1 : 0;
  endfunction

  function automatic logic [11:0] boom_val();
    return (boom_mode == 0) ? 12'hFFF : 12'hF80;
  endfunction

  assign tank_data = 2'(rom_idx(int'(tank_addr)));
  assign boom_data = boom_val();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sprite geometry as rotations of the (row, col) offset inside a 32x32 tile.
  function automatic bit in_win(input int pc, input int pr, input int lx, input int ly);
    int c0, r0;
    c0 = (lx * 8) % 4096;
    r0 = (ly * 6) % 4096;
    return (pc >= c0) && (pc - c0 < 32) && (pr >= r0) && (pr - r0 < 32);
  endfunction

  function automatic int map_addr(input int pc, input int pr, input int lx, input int ly,
                                  input int ori);
    int c, r;
    c = ((pc - (lx * 8) % 4096) + 4096) % 4096 % 32;
    r = ((pr - (ly * 6) % 4096) + 4096) % 4096 % 32;
    case (ori)
      0: return r * 32 + c;
      1: return (31 - c) * 32 + r;
      2: return (31 - r) * 32 + (31 - c);
      default: return c * 32 + (31 - r);
    endcase
  endfunction

  // Model: m_tt counts clocks since the accepted hit; phases are ranges of it.
  bit          m_active;
  int          m_tt, m_orient;
  bit          s1_win, s1_gate, s1_burst;
  int          s1_addr, s1_frame;
  bit          m_icon;
  logic [11:0] m_icon_c;

  function automatic bit ph_burst(input bit a, input int t);
    return a && (t < BLT);
  endfunction
  function automatic bit ph_resp(input bit a, input int t);
    return a && (t >= BLT) && (t < BLT + RP);
  endfunction
  function automatic bit ph_guard(input bit a, input int t);
    return a && (t >= BLT + RP);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;  m_tt <= 0;     m_orient <= 0;
      s1_win   <= 1'b0;  s1_gate <= 1'b0; s1_burst <= 1'b0;
      s1_addr  <= 0;     s1_frame <= 0;
      m_icon   <= 1'b0;  m_icon_c <= 12'h000;
    end else begin
      m_icon <= 1'b0;
      if (s1_win && s1_gate) begin
        if (s1_burst) begin
          m_icon   <= (boom_val() != 12'hFFF);
          m_icon_c <= boom_val();
        end else begin
          case (rom_idx(s1_addr))
            1: begin m_icon <= 1'b1; m_icon_c <= 12'h000; end
            2: begin m_icon <= 1'b1; m_icon_c <= 12'h00F; end
            3: begin m_icon <= 1'b1; m_icon_c <= 12'h025; end
            default: ;
          endcase
        end
      end
      s1_win   <= in_win(pixel_column, pixel_row, loc_x, loc_y);
      s1_addr  <= map_addr(pixel_column, pixel_row, loc_x, loc_y,
                           bot_info[0] ? m_orient : int'(bot_info[2:1]));
      s1_burst <= ph_burst(m_active, m_tt);
      s1_frame <= ph_burst(m_active, m_tt) ? m_tt / FC : 0;
      s1_gate  <= !ph_guard(m_active, m_tt) || (((m_tt - BLT - RP) >> BL) & 1) == 1;
      if (!bot_info[0]) m_orient <= int'(bot_info[2:1]);
      if (!m_active) begin
        if (hit) begin m_active <= 1'b1; m_tt <= 0; end
      end else if (m_tt == TOT - 1) begin
        m_active <= 1'b0;
      end else begin
        m_tt <= m_tt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("tank_addr", 32'(tank_addr), 32'(s1_addr));
      check("boom_addr", 32'(boom_addr), 32'(s1_frame * 1024 + s1_addr));
      check("icon", 32'(icon), 32'(m_icon));
      check("icon_c", 32'(icon_c), 32'(m_icon_c));
      check("burst", 32'(burst), 32'(ph_burst(m_active, m_tt)));
      check("tank_reset", 32'(tank_reset), 32'(ph_resp(m_active, m_tt)));
      check("guard", 32'(guard), 32'(ph_guard(m_active, m_tt)));
    end
  end

  // Drive one pixel from a parked (outside) pixel; icon must stay 0 after one
  // clock and show the result after exactly two.
  task automatic probe(input int col, input int row, input bit exp_icon,
                       input logic [11:0] exp_c, input string name);
    pixel_column = 12'(col);
    pixel_row    = 12'(row);
    @(negedge clk);
    check({name, "_lat1"}, 32'(icon), 32'd0);
    @(negedge clk);
    check(name, 32'(icon), 32'(exp_icon));
    if (exp_icon) check({name, "_c"}, 32'(icon_c), 32'(exp_c));
    pixel_column = 12'd0;
    pixel_row    = 12'd0;
    repeat (2) @(negedge clk);
  endtask

  bit rb[0:99], rt[0:99], rg[0:99];
  int rm[0:99];

  initial begin
    int nb, nt, ng, fb, ft, fg, lg;
    reset = 1'b0;
    pixel_column = 12'd0; pixel_row = 12'd0;
    loc_x = 8'd0; loc_y = 8'd0; bot_info = 8'd0; hit = 1'b0;
    rom_mode = 0; boom_mode = 1;
    repeat (3) @(negedge clk);
    check("rst_icon", 32'(icon), 32'd0);
    check("rst_icon_c", 32'(icon_c), 32'd0);
    check("rst_burst", 32'(burst), 32'd0);
    check("rst_tank_reset", 32'(tank_reset), 32'd0);
    check("rst_guard", 32'(guard), 32'd0);
    check("rst_tank_addr", 32'(tank_addr), 32'd0);
    check("rst_boom_addr", 32'(boom_addr), 32'd0);
    reset = 1'b1;
    loc_x = 8'd10; loc_y = 8'd20;
    repeat (2) @(negedge clk);

    // Window spans columns 80..111, rows 120..151.
    probe(80, 120, 1'b1, 12'h00F, "pos_tl");
    probe(111, 151, 1'b1, 12'h00F, "pos_br");
    probe(79, 120, 1'b0, 12'h000, "col79");
    probe(112, 120, 1'b0, 12'h000, "col112");
    probe(80, 119, 1'b0, 12'h000, "row119");
    probe(80, 152, 1'b0, 12'h000, "row152");

    rom_mode = 1;
    bot_info = 8'b000; probe(80, 120, 1'b1, 12'h000, "ori_n");
    probe(81, 120, 1'b0, 12'h000, "ori_n_neg");
    bot_info = 8'b010; probe(111, 120, 1'b1, 12'h000, "ori_e");
    probe(80, 120, 1'b0, 12'h000, "ori_e_neg");
    bot_info = 8'b100; probe(111, 151, 1'b1, 12'h000, "ori_s");
    bot_info = 8'b110; probe(80, 151, 1'b1, 12'h000, "ori_w");
    bot_info = 8'b010; @(negedge clk);
    bot_info = 8'b011; probe(111, 120, 1'b1, 12'h000, "ori_diag_keeps_e");

    // Explosion sequence with a pixel parked inside the sprite.
    bot_info = 8'b000; rom_mode = 0; boom_mode = 1;
    pixel_column = 12'd80; pixel_row = 12'd120;
    repeat (3) @(negedge clk);
    hit = 1'b1;
    for (int j = 1; j <= 98; j++) begin
      @(negedge clk);
      rb[j] = burst; rt[j] = tank_reset; rg[j] = guard; rm[j] = int'(boom_addr[11:10]);
      hit = (j == 5 || j == 20 || j == 50 || j == 97);
    end
    nb = 0; nt = 0; ng = 0; fb = 0; ft = 0; fg = 0; lg = 0;
    for (int j = 1; j <= 96; j++) begin
      if (rb[j]) begin nb++; if (fb == 0) fb = j; end
      if (rt[j]) begin nt++; if (ft == 0) ft = j; end
      if (rg[j]) begin ng++; if (fg == 0) fg = j; lg = j; end
    end
    check("burst_len", 32'(nb), 32'd16);
    check("burst_start", 32'(fb), 32'd1);
    check("reset_len", 32'(nt), 32'd16);
    check("reset_start", 32'(ft), 32'd17);
    check("guard_len", 32'(ng), 32'd64);
    check("guard_start", 32'(fg), 32'd33);
    check("guard_end", 32'(lg), 32'd96);
    check("alive_after_guard", 32'(rg[97]), 32'd0);
    check("frame0", 32'(rm[2]), 32'd0);
    check("frame1", 32'(rm[6]), 32'd1);
    check("frame2", 32'(rm[10]), 32'd2);
    check("frame3", 32'(rm[14]), 32'd3);
    check("rehit_burst", 32'(rb[98]), 32'd1);

    // Transparency during the new explosion.
    boom_mode = 0;
    repeat (2) @(negedge clk);
    check("boom_fff_icon", 32'(icon), 32'd0);
    check("boom_fff_burst", 32'(burst), 32'd1);
    boom_mode = 1;
    repeat (2) @(negedge clk);
    check("boom_f80_icon", 32'(icon), 32'd1);
    check("boom_f80_c", 32'(icon_c), 32'h F80);

    // Abort during frame 2.
    repeat (5) @(negedge clk);
    check("abort_frame2", 32'(boom_addr[11:10]), 32'd2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_burst", 32'(burst), 32'd0);
    check("abort_icon", 32'(icon), 32'd0);
    check("abort_icon_c", 32'(icon_c), 32'd0);
    check("abort_boom_addr", 32'(boom_addr), 32'd0);
    check("abort_tank_reset", 32'(tank_reset), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    nt = 0; nb = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (tank_reset) nt++;
      if (burst) nb++;
    end
    check("abort_no_pulse", 32'(nt), 32'd0);
    check("abort_no_burst", 32'(nb), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tank_sprite_gen2.md
Name: tank_sprite_gen2

Overview:
- Parametrised successor to the single-tank icon renderer.
- Maps a robot's 128x128 world position to display coordinates and renders a square sprite in one of four orientations.
- Plays a multi-frame explosion when hit, then issues a respawn pulse and a blinking invulnerability window.
- Sits between the display timing generator / bot-info registers and the colourizer; one instance per tank.

Parameters:
SPR_LOG2, 5, log2 of sprite edge in pixels (edge SPR_W = 2^SPR_LOG2 = 32)
SCALE_X, 8, display pixels per world X unit
SCALE_Y, 6, display pixels per world Y unit
BOOM_FRAMES_LOG2, 2, log2 of explosion frame count (4 frames)
FRAME_CYCLES, 12500000, clocks per explosion frame
RESET_PULSE, 16, width of tank_reset pulse in clocks
GUARD_CYCLES, 50000000, invulnerability duration in clocks
BLINK_LOG2, 22, guard-blink counter bit used to toggle visibility
TANK_COLOR, 12'h00F, RGB for palette index 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pixel_column  in  12  current display column
pixel_row  in  12  current display row
loc_x  in  8  world X position
loc_y  in  8  world Y position
bot_info  in  8  [2:0] = orientation code
hit  in  1  hit strobe, level or pulse
tank_addr  out  2*SPR_LOG2  tank ROM address, synchronous ROM, 1-cycle read
tank_data  in  2  tank ROM palette index
boom_addr  out  BOOM_FRAMES_LOG2+2*SPR_LOG2  explosion ROM address
boom_data  in  12  explosion ROM RGB
icon  out  1  sprite pixel opaque this pixel
icon_c  out  12  sprite RGB
burst  out  1  explosion in progress
tank_reset  out  1  respawn request pulse
guard  out  1  invulnerability window active

Behaviour:
- Reset (reset=0, async): state ALIVE; icon=0, icon_c=0, burst=0, tank_reset=0, guard=0; all counters 0; stored orientation = North; ROM addresses 0.
- Origin: col0 = loc_x*SCALE_X and row0 = loc_y*SCALE_Y, each computed in 12 bits.
  - Window test: pixel_column >= col0 && (pixel_column - col0) < SPR_W, and the same for rows.
  - Never form col0 + SPR_W, so no 12-bit overflow.
- Offsets: r = pixel_row - row0 and c = pixel_column - col0, each truncated to SPR_LOG2 bits.
- Orientation from bot_info[2:0]:
  - 000 N: addr = {r, c}
  - 010 E: addr = {~c, r}
  - 100 S: addr = {~r, ~c}
  - 110 W: addr = {c, ~r}
  - Odd codes (diagonals) keep the last stored cardinal orientation.
  - Orientation is latched on every cycle where bot_info[0]==0.
- Pipeline, fixed latency 2 clocks from pixel input to icon/icon_c:
  - Stage 1 registers tank_addr/boom_addr, the in-window flag and the visible-gate.
  - Stage 2 registers icon/icon_c from ROM data.
  - Address, window flag and gate must stay aligned through both stages.
- Colour, tank (state != BURST): palette 0 transparent (icon=0), 1 = 12'h000, 2 = TANK_COLOR, 3 = 12'h025.
- Colour, BURST: icon_c = boom_data; icon = (boom_data != 12'hFFF).
- Outside the window, or when the gate is off: icon = 0 and icon_c holds its previous value.
- boom_addr = {frame_idx, orientation-mapped address}.
- State machine:
  - ALIVE: hit=1 -> BURST next clock; frame_idx = 0, cycle counter = 0, burst = 1.
  - BURST: the counter counts to FRAME_CYCLES-1, then frame_idx increments. After the last frame's final cycle -> RESPAWN; burst = 0.
  - RESPAWN: tank_reset = 1 for exactly RESET_PULSE clocks, then -> GUARD; guard = 1.
  - GUARD: the sprite gate equals blink counter bit BLINK_LOG2 (1 = visible). After GUARD_CYCLES clocks -> ALIVE; guard = 0, gate forced visible.
- hit is ignored in BURST, RESPAWN and GUARD. A hit held high through to ALIVE re-triggers BURST on the first ALIVE cycle.
- Asserting reset mid-explosion aborts immediately to the reset values, with no tank_reset pulse.
- All counters are sized to hold their parameter values without wrap.

Test Plan:
- Position and latency: loc_x=10, loc_y=20, N, ROM all index 2. Expect icon=1, icon_c=12'h00F exactly 2 clocks after the pixel enters columns 80..111 and rows 120..151; icon=0 at columns 79 and 112.
- Orientation: ROM index = 1 only at address 0. Expect the black pixel at (row0, col0) for N, (row0, col0+31) for E, (row0+31, col0+31) for S, (row0+31, col0) for W. Code 011 after E keeps the E mapping.
- Explosion (FRAME_CYCLES=4, RESET_PULSE=16, GUARD_CYCLES=64): 1-clock hit strobe. Expect burst high for 16 clocks, boom_addr MSBs stepping 0,1,2,3 every 4 clocks, then tank_reset high for exactly 16 clocks, then guard high for 64 clocks.
- Hit immunity: repeated hit strobes during BURST, RESPAWN and GUARD leave all timing unchanged. A hit 1 clock after guard falls re-enters BURST.
- Transparency: boom_data = 12'hFFF during burst gives icon=0; 12'hF80 gives icon=1, icon_c=12'hF80.
- Reset abort: assert reset during frame 2. Outputs go to 0 asynchronously, with no tank_reset pulse after release.
